// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio output path: DAC serializer states,
// frame width and the saturating three-source mixer.
`timescale 1ns/1ps
package audio_pkg;

   localparam int unsigned FRAME_BITS = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } dac_state_t;

   // Sum three unsigned 8-bit amplitudes at 10 bits and clip to full scale.
   function automatic logic [7:0] sat_add3(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c);
      logic [9:0] sum;
      sum = 10'(a) + 10'(b) + 10'(c);
      return (sum > 10'd255) ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/audio_dac_output_stage_if.sv
// Audio sources from the music box controller plus the SPI lines to the DAC.
`timescale 1ns/1ps
interface audio_dac_output_stage_if;

   logic [7:0]  song0_in;
   logic [7:0]  song1_in;
   logic [15:0] recording_in;
   logic        mute;
   logic        dac_sclk;
   logic        dac_mosi;
   logic        dac_cs_n;

   modport master (
      input  song0_in,
      input  song1_in,
      input  recording_in,
      input  mute,
      output dac_sclk,
      output dac_mosi,
      output dac_cs_n
   );

   modport slave (
      output song0_in,
      output song1_in,
      output recording_in,
      output mute,
      input  dac_sclk,
      input  dac_mosi,
      input  dac_cs_n
   );

endinterface

// File: rtl/tick_edge_sync.sv
// Two-flop synchronizer for a slow asynchronous clock, followed by a
// registered rising-edge detector producing a one-cycle pulse.
`timescale 1ns/1ps
module tick_edge_sync (
   input  logic clock_50Mhz,
   input  logic reset_n,
   input  logic async_in,
   output logic pulse
);

   logic [1:0] sync_q;
   logic       prev_q;

   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b00;
         prev_q <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], async_in};
         prev_q <= sync_q[1];
         pulse  <= sync_q[1] & ~prev_q;
      end
   end

endmodule

// File: rtl/audio_dac_output_stage.sv
// Saturating three-source mixer latched once per sample tick and serialized
// as a 16-bit {control, sample, pad} frame to an external SPI DAC.
`timescale 1ns/1ps
module audio_dac_output_stage
   import audio_pkg::*;
#(
   parameter int unsigned SCLK_DIV    = 4,
   parameter logic [3:0]  CTRL_NIBBLE = 4'b0111,
   parameter logic [7:0]  MUTE_LEVEL  = 8'd0
) (
   input  logic                     clock_50Mhz,
   input  logic                     reset_n,
   input  logic                     sample_tick_in,
   audio_dac_output_stage_if.master bus,
   output logic [7:0]               mixed_sample,
   output logic                     frame_busy,
   output logic                     overrun
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned BIT_W = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_DIV - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS - 1);

   dac_state_t            state, state_n;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [BIT_W-1:0]      bit_idx, bit_idx_n;
   logic                  sclk_hi, sclk_hi_n;
   logic [FRAME_BITS-1:0] shift, shift_n;
   logic                  sclk_q, sclk_n;
   logic                  cs_n_q, cs_n_n;
   logic                  busy_n;
   logic                  overrun_n;

   logic                  tick;
   logic                  half_done;
   logic                  accept;
   logic [7:0]            sample_c;
   logic [FRAME_BITS-1:0] frame_c;
   logic                  unused_rec_low;

   tick_edge_sync u_tick_sync (
      .clock_50Mhz (clock_50Mhz),
      .reset_n     (reset_n),
      .async_in    (sample_tick_in),
      .pulse       (tick)
   );

   assign sample_c  = bus.mute ? MUTE_LEVEL
                               : sat_add3(bus.song0_in, bus.song1_in, bus.recording_in[15:8]);
   assign frame_c   = {CTRL_NIBBLE, sample_c, 4'b0000};
   assign half_done = (cnt == HALF_LAST);
   // A tick landing on the last GAP cycle starts the next frame back-to-back.
   assign accept    = tick && ((state == IDLE) || ((state == GAP) && half_done));
   assign unused_rec_low = ^bus.recording_in[7:0];

   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         sclk_hi      <= 1'b0;
         shift        <= '0;
         sclk_q       <= 1'b0;
         cs_n_q       <= 1'b1;
         frame_busy   <= 1'b0;
         overrun      <= 1'b0;
         mixed_sample <= 8'd0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= bit_idx_n;
         sclk_hi    <= sclk_hi_n;
         shift      <= shift_n;
         sclk_q     <= sclk_n;
         cs_n_q     <= cs_n_n;
         frame_busy <= busy_n;
         overrun    <= overrun_n;
         if (tick) begin
            mixed_sample <= sample_c;
         end
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = ((state == IDLE) || half_done) ? '0 : cnt + 1'b1;
      bit_idx_n = bit_idx;
      sclk_hi_n = sclk_hi;
      shift_n   = shift;
      sclk_n    = sclk_q;
      cs_n_n    = cs_n_q;
      busy_n    = frame_busy;
      overrun_n = tick & ~accept;

      unique case (state)
         IDLE: begin
            cs_n_n = 1'b1;
            sclk_n = 1'b0;
         end
         SETUP: begin
            if (half_done) begin
               state_n   = SHIFT;
               sclk_n    = 1'b1;
               sclk_hi_n = 1'b1;
               bit_idx_n = '0;
            end
         end
         SHIFT: begin
            if (half_done) begin
               if (sclk_hi) begin
                  // Next bit is presented on the falling edge, except after the last bit.
                  sclk_n    = 1'b0;
                  sclk_hi_n = 1'b0;
                  if (bit_idx != LAST_BIT) begin
                     shift_n = {shift[FRAME_BITS-2:0], 1'b0};
                  end
               end else if (bit_idx == LAST_BIT) begin
                  state_n = HOLD;
               end else begin
                  bit_idx_n = bit_idx + 1'b1;
                  sclk_hi_n = 1'b1;
                  sclk_n    = 1'b1;
               end
            end
         end
         HOLD: begin
            if (half_done) begin
               state_n = GAP;
               cs_n_n  = 1'b1;
               shift_n = '0;
            end
         end
         GAP: begin
            if (half_done) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (accept) begin
         state_n = SETUP;
         cnt_n   = '0;
         shift_n = frame_c;
         sclk_n  = 1'b0;
         cs_n_n  = 1'b0;
         busy_n  = 1'b1;
      end
   end

   assign bus.dac_sclk = sclk_q;
   assign bus.dac_cs_n = cs_n_q;
   assign bus.dac_mosi = shift[FRAME_BITS-1];

endmodule

// File: tb/tb_audio_dac_output_stage.sv
// Directed bench for audio_dac_output_stage: decodes SPI frames off the pins and
// compares them with hand-computed mixes, saturation, mute, overrun and reset.
`timescale 1ns/1ps
module tb_audio_dac_output_stage;

   logic       clock_50Mhz    = 1'b0;
   logic       reset_n        = 1'b0;
   logic       sample_tick_in = 1'b0;
   logic [7:0] mixed_sample;
   logic       frame_busy;
   logic       overrun;

   audio_dac_output_stage_if dac_if ();

   audio_dac_output_stage #(
      .SCLK_DIV    (4),
      .CTRL_NIBBLE (4'b0111),
      .MUTE_LEVEL  (8'd0)
   ) dut (
      .clock_50Mhz    (clock_50Mhz),
      .reset_n        (reset_n),
      .sample_tick_in (sample_tick_in),
      .bus            (dac_if),
      .mixed_sample   (mixed_sample),
      .frame_busy     (frame_busy),
      .overrun        (overrun)
   );

   always #10 clock_50Mhz = ~clock_50Mhz;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Pin-level frame decoder, sampled on the falling clock edge.
   logic        cs_prev = 1'b1, sclk_prev = 1'b0, busy_prev = 1'b0;
   logic [15:0] cur_sh = '0, last_frame = '0;
   int          cur_bits = 0, cur_low = 0, last_bits = 0, last_low = 0;
   int          frame_cnt = 0, cs_falls = 0, ovr_cnt = 0, busy_cyc = 0, last_busy = 0;
   logic [15:0] frames_q[$];

   always @(negedge clock_50Mhz) begin
      if (!dac_if.dac_cs_n) begin
         if (cs_prev) begin
            cur_sh = '0; cur_bits = 0; cur_low = 0; cs_falls++;
         end
         cur_low++;
         if (dac_if.dac_sclk && !sclk_prev) begin
            cur_sh = {cur_sh[14:0], dac_if.dac_mosi};
            cur_bits++;
         end
      end else if (!cs_prev) begin
         last_frame = cur_sh; last_bits = cur_bits; last_low = cur_low;
         frame_cnt++;
         frames_q.push_back(cur_sh);
      end
      if (frame_busy) busy_cyc++;
      else if (busy_prev) begin
         last_busy = busy_cyc; busy_cyc = 0;
      end
      if (overrun) ovr_cnt++;
      cs_prev = dac_if.dac_cs_n; sclk_prev = dac_if.dac_sclk; busy_prev = frame_busy;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clock_50Mhz);
         #1;
      end
   endtask

   task automatic set_inputs(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [15:0] rec, input logic m);
      dac_if.song0_in     = s0;
      dac_if.song1_in     = s1;
      dac_if.recording_in = rec;
      dac_if.mute         = m;
   endtask

   task automatic send_tick();
      sample_tick_in = 1'b1;
      step(10);
      sample_tick_in = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         step(1);
         if (frame_cnt >= target && !frame_busy) break;
      end
      check_eq("frame_count", 32'(frame_cnt), 32'(target));
   endtask

   function automatic logic [7:0] ref_mix(input int a, input int b, input int c, input logic m);
      int s;
      s = a + b + c;
      if (m) return 8'd0;
      return (s > 255) ? 8'hFF : 8'(s);
   endfunction

   typedef struct {
      logic [7:0]  s0;
      logic [7:0]  s1;
      logic [15:0] rec;
      logic        m;
      logic [7:0]  exp;
   } vec_t;

   vec_t       vecs[6];
   logic [7:0] exp_q[$];

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int f0, o0, fall0;

      vecs[0] = '{8'h40, 8'h20, 16'h1000, 1'b0, 8'h70};
      vecs[1] = '{8'hC8, 8'hC8, 16'hFFFF, 1'b0, 8'hFF};
      vecs[2] = '{8'hAA, 8'hBB, 16'hCCDD, 1'b1, 8'h00};
      vecs[3] = '{8'h80, 8'h7F, 16'h0000, 1'b0, 8'hFF};
      vecs[4] = '{8'h80, 8'h7E, 16'h00FF, 1'b0, 8'hFE};
      vecs[5] = '{8'h01, 8'h00, 16'hFF00, 1'b0, 8'hFF};

      set_inputs(8'h00, 8'h00, 16'h0000, 1'b0);
      step(3);
      check_eq("rst_cs_n",   32'(dac_if.dac_cs_n), 32'd1);
      check_eq("rst_sclk",   32'(dac_if.dac_sclk), 32'd0);
      check_eq("rst_mosi",   32'(dac_if.dac_mosi), 32'd0);
      check_eq("rst_mixed",  32'(mixed_sample),    32'd0);
      check_eq("rst_busy",   32'(frame_busy),      32'd0);
      check_eq("rst_ovr",    32'(overrun),         32'd0);
      reset_n = 1'b1;
      step(3);

      // Tick latency and the first frame
      set_inputs(vecs[0].s0, vecs[0].s1, vecs[0].rec, vecs[0].m);
      sample_tick_in = 1'b1;
      step(3);
      check_eq("cs_lat_early", 32'(dac_if.dac_cs_n), 32'd1);
      check_eq("mixed_early",  32'(mixed_sample),    32'd0);
      step(1);
      check_eq("cs_lat",       32'(dac_if.dac_cs_n), 32'd0);
      check_eq("mixed_lat",    32'(mixed_sample),    32'h70);
      check_eq("busy_lat",     32'(frame_busy),      32'd1);
      step(6);
      sample_tick_in = 1'b0;
      wait_frames(1, 400);
      check_eq("v0_frame", 32'(last_frame), 32'h7700);
      check_eq("v0_bits",  32'(last_bits),  32'd16);
      check_eq("v0_low",   32'(last_low),   32'd136);
      check_eq("v0_busy",  32'(last_busy),  32'd140);
      step(20);

      // Mixing, saturation boundaries and mute
      for (int i = 1; i < 6; i++) begin
         f0 = frame_cnt;
         set_inputs(vecs[i].s0, vecs[i].s1, vecs[i].rec, vecs[i].m);
         send_tick();
         wait_frames(f0 + 1, 400);
         check_eq($sformatf("v%0d_mixed", i), 32'(mixed_sample), 32'(vecs[i].exp));
         check_eq($sformatf("v%0d_frame", i), 32'(last_frame), 32'({4'h7, vecs[i].exp, 4'h0}));
         check_eq($sformatf("v%0d_low", i),   32'(last_low),   32'd136);
         step(20);
      end

      // Second tick mid-frame: overrun, no queued frame
      f0 = frame_cnt;
      o0 = ovr_cnt;
      set_inputs(8'h10, 8'h20, 16'h0300, 1'b0);
      send_tick();
      step(40);
      set_inputs(8'h05, 8'h06, 16'h0700, 1'b0);
      send_tick();
      wait_frames(f0 + 1, 400);
      check_eq("ovr_cycles",  32'(ovr_cnt - o0), 32'd1);
      check_eq("ovr_frame",   32'(last_frame),   32'h7330);
      check_eq("ovr_mixed",   32'(mixed_sample), 32'h12);
      step(50);
      check_eq("ovr_noqueue", 32'(frame_cnt),    32'(f0 + 1));
      set_inputs(8'h01, 8'h02, 16'h0300, 1'b0);
      send_tick();
      wait_frames(f0 + 2, 400);
      check_eq("post_ovr_frame", 32'(last_frame), 32'h7060);
      check_eq("post_ovr_low",   32'(last_low),   32'd136);
      step(20);

      // Reset at the 8th SCLK rising edge
      set_inputs(8'h11, 8'h22, 16'h3300, 1'b0);
      send_tick();
      for (int i = 0; i < 200; i++) begin
         if (!dac_if.dac_cs_n && cur_bits == 8) break;
         step(1);
      end
      check_eq("rst_mid_bits", 32'(cur_bits),        32'd8);
      check_eq("rst_mid_sclk", 32'(dac_if.dac_sclk), 32'd1);
      reset_n = 1'b0;
      #1;
      check_eq("rst_mid_cs_n",  32'(dac_if.dac_cs_n), 32'd1);
      check_eq("rst_mid_sclk0", 32'(dac_if.dac_sclk), 32'd0);
      check_eq("rst_mid_mosi",  32'(dac_if.dac_mosi), 32'd0);
      check_eq("rst_mid_busy",  32'(frame_busy),      32'd0);
      check_eq("rst_mid_mixed", 32'(mixed_sample),    32'd0);
      step(3);
      reset_n = 1'b1;
      fall0 = cs_falls;
      step(300);
      check_eq("rst_no_resume", 32'(cs_falls - fall0), 32'd0);
      check_eq("rst_idle_cs_n", 32'(dac_if.dac_cs_n),  32'd1);

      // Periodic ticks with ramp inputs
      frames_q.delete();
      o0 = ovr_cnt;
      for (int i = 0; i < 20; i++) begin
         logic [7:0]  s0, s1;
         logic [15:0] rec;
         logic        m;
         s0  = 8'(i * 13);
         s1  = 8'(i * 17);
         rec = {8'(i * 29), 8'h5A};
         m   = (i == 9);
         exp_q.push_back(ref_mix(int'(s0), int'(s1), int'(rec[15:8]), m));
         set_inputs(s0, s1, rec, m);
         send_tick();
         step(290);
      end
      check_eq("ramp_frames",  32'(frames_q.size()), 32'd20);
      check_eq("ramp_overrun", 32'(ovr_cnt - o0),    32'd0);
      for (int i = 0; i < 20; i++) begin
         if (i < frames_q.size()) begin
            check_eq($sformatf("ramp_%0d", i), 32'(frames_q[i]), 32'({4'h7, exp_q[i], 4'h0}));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
